// File: rtl/dtbdm_window_gen.sv
// Streaming 3x3 zero-padded neighbourhood generator: raster pixels in, one window per pixel out.
// Pixels live in a (2W+4)-entry ring addressed by linear pixel index modulo the ring depth.
module dtbdm_window_gen #(
   parameter int pImageWidth = 512,
   parameter int pImageHight = 512,
   parameter int pPixelW     = 8
) (
   input  logic               iClk,
   input  logic               iRst,
   input  logic               iPixelValid,
   input  logic [pPixelW-1:0] iv8Pixel,
   output logic               oReady,
   output logic [pPixelW-1:0] ov8Pixel_a,
   output logic [pPixelW-1:0] ov8Pixel_b,
   output logic [pPixelW-1:0] ov8Pixel_c,
   output logic [pPixelW-1:0] ov8Pixel_d,
   output logic [pPixelW-1:0] ov8Pixel_fij,
   output logic [pPixelW-1:0] ov8Pixel_e,
   output logic [pPixelW-1:0] ov8Pixel_f,
   output logic [pPixelW-1:0] ov8Pixel_g,
   output logic [pPixelW-1:0] ov8Pixel_h,
   output logic               oWindowValid,
   input  logic               iWindowReady,
   output logic               oFrameDone
);
   localparam int cW     = pImageWidth;
   localparam int cH     = pImageHight;
   localparam int cN     = cW * cH;
   localparam int cDepth = 2 * cW + 4;
   localparam int cIdxW  = $clog2(cN + 1) + 1;
   localparam int cPtrW  = $clog2(cDepth);
   localparam int cRowW  = $clog2(cH + 1);
   localparam int cColW  = $clog2(cW + 1);

   typedef logic [cIdxW-1:0] idx_t;
   localparam idx_t cNIdx    = idx_t'(cN);
   localparam idx_t cLead    = idx_t'(cW + 2);
   localparam idx_t cMaxDiff = idx_t'(cW + 3);

   logic [pPixelW-1:0] mem [cDepth];
   logic [pPixelW-1:0] winD [9];
   logic [pPixelW-1:0] winQ [9];

   idx_t             inIdx, outIdx, nxtIn, nxtOut, lead;
   logic [cPtrW-1:0] wrPtr, cPtr, nxtWr, nxtC;
   logic [cRowW-1:0] outRow, nxtRow;
   logic [cColW-1:0] outCol, nxtCol;
   logic             accept, winHs, lastHs, avail, load, rdyNxt;

   assign accept = iPixelValid && oReady;
   assign winHs  = oWindowValid && iWindowReady;
   assign lastHs = winHs && (outIdx == cNIdx - idx_t'(1));

   always_comb begin
      nxtIn  = inIdx;
      nxtOut = outIdx;
      nxtWr  = wrPtr;
      nxtC   = cPtr;
      nxtRow = outRow;
      nxtCol = outCol;
      if (accept) begin
         nxtIn = inIdx + idx_t'(1);
         nxtWr = (wrPtr == cPtrW'(cDepth - 1)) ? '0 : wrPtr + cPtrW'(1);
      end
      if (winHs) begin
         nxtOut = outIdx + idx_t'(1);
         nxtC   = (cPtr == cPtrW'(cDepth - 1)) ? '0 : cPtr + cPtrW'(1);
         if (outCol == cColW'(cW - 1)) begin
            nxtCol = '0;
            nxtRow = outRow + cRowW'(1);
         end else begin
            nxtCol = outCol + cColW'(1);
         end
      end
      // Frame wrap: the ring restarts at slot 0 with the next frame.
      if (lastHs) begin
         nxtIn  = '0;
         nxtOut = '0;
         nxtWr  = '0;
         nxtC   = '0;
         nxtRow = '0;
         nxtCol = '0;
      end
   end

   // Availability uses the registered in_idx: the pixel accepted this cycle is not in the ring yet.
   assign lead   = (nxtOut + cLead > cNIdx) ? cNIdx : nxtOut + cLead;
   assign avail  = !lastHs && (nxtOut < cNIdx) && (inIdx >= lead);
   assign load   = (!oWindowValid || winHs) && avail;
   assign rdyNxt = (nxtIn < cNIdx) && ((nxtIn - nxtOut) < cMaxDiff);

   always_comb begin
      int rr, cc, addr;
      rr   = 0;
      cc   = 0;
      addr = 0;
      for (int k = 0; k < 9; k++) begin
         rr   = int'(nxtRow) + k / 3 - 1;
         cc   = int'(nxtCol) + k % 3 - 1;
         addr = int'(nxtC) + (k / 3 - 1) * cW + (k % 3 - 1);
         if (addr < 0) addr = addr + cDepth;
         else if (addr >= cDepth) addr = addr - cDepth;
         winD[k] = (rr >= 0 && rr < cH && cc >= 0 && cc < cW) ? mem[addr[cPtrW-1:0]] : '0;
      end
   end

   always_ff @(posedge iClk) begin
      if (!iRst && accept) mem[wrPtr] <= iv8Pixel;
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         inIdx        <= '0;
         outIdx       <= '0;
         wrPtr        <= '0;
         cPtr         <= '0;
         outRow       <= '0;
         outCol       <= '0;
         oReady       <= 1'b0;
         oFrameDone   <= 1'b0;
         oWindowValid <= 1'b0;
         winQ         <= '{default: '0};
      end else begin
         inIdx      <= nxtIn;
         outIdx     <= nxtOut;
         wrPtr      <= nxtWr;
         cPtr       <= nxtC;
         outRow     <= nxtRow;
         outCol     <= nxtCol;
         oReady     <= rdyNxt;
         oFrameDone <= lastHs;
         if (load) begin
            oWindowValid <= 1'b1;
            winQ         <= winD;
         end else if (winHs) begin
            oWindowValid <= 1'b0;
         end
      end
   end

   assign ov8Pixel_a   = winQ[0];
   assign ov8Pixel_b   = winQ[1];
   assign ov8Pixel_c   = winQ[2];
   assign ov8Pixel_d   = winQ[3];
   assign ov8Pixel_fij = winQ[4];
   assign ov8Pixel_e   = winQ[5];
   assign ov8Pixel_f   = winQ[6];
   assign ov8Pixel_g   = winQ[7];
   assign ov8Pixel_h   = winQ[8];
endmodule

// File: tb/tb_dtbdm_window_gen.sv
// Bench for dtbdm_window_gen at W=H=4: spot-check table plus a raster golden model of padded windows.
module tb_dtbdm_window_gen;
   localparam int W = 4;
   localparam int H = 4;
   localparam int N = W * H;

   logic       iClk = 1'b0;
   logic       iRst, iPixelValid, iWindowReady;
   logic [7:0] iv8Pixel;
   logic       oReady, oWindowValid, oFrameDone;
   logic [7:0] pa, pb, pc, pd, pfij, pe, pf, pg, ph;
   logic [71:0] winOut;

   dtbdm_window_gen #(.pImageWidth(W), .pImageHight(H), .pPixelW(8)) dut (
      .iClk(iClk), .iRst(iRst), .iPixelValid(iPixelValid), .iv8Pixel(iv8Pixel),
      .oReady(oReady), .ov8Pixel_a(pa), .ov8Pixel_b(pb), .ov8Pixel_c(pc),
      .ov8Pixel_d(pd), .ov8Pixel_fij(pfij), .ov8Pixel_e(pe), .ov8Pixel_f(pf),
      .ov8Pixel_g(pg), .ov8Pixel_h(ph), .oWindowValid(oWindowValid),
      .iWindowReady(iWindowReady), .oFrameDone(oFrameDone)
   );

   always #5 iClk = ~iClk;
   assign winOut = {pa, pb, pc, pd, pfij, pe, pf, pg, ph};

   typedef struct {
      int          idx;
      logic [71:0] exp;
   } spot_t;

   spot_t       tbl [5];
   logic [7:0]  pix [64];
   logic [71:0] got [64];
   int nvec = 0, nerr = 0;
   int pi, wi, totalPix, cyc = 0, acc6 = -100, fdCount;
   bit chkLat = 0;

   task automatic chk(input string nm, input logic [79:0] g, input logic [79:0] e);
      nvec++;
      if (g !== e) begin
         nerr++;
         $display("FAIL %s got=%0h exp=%0h", nm, g, e);
      end
   endtask

   // Window w of the run: frame w/N, centre (r,c); any neighbour outside the image is zero.
   function automatic logic [71:0] expWin(int w);
      int f, r, c, rr, cc;
      logic [71:0] res;
      f = w / N; r = (w % N) / W; c = w % W; res = '0;
      for (int k = 0; k < 9; k++) begin
         rr = r + k / 3 - 1;
         cc = c + k % 3 - 1;
         if (rr >= 0 && rr < H && cc >= 0 && cc < W)
            res[(8 - k) * 8 +: 8] = pix[f * N + rr * W + cc];
      end
      return res;
   endfunction

   task automatic newFrames(input int nf, input bit rnd);
      totalPix = nf * N; pi = 0; wi = 0; fdCount = 0;
      for (int i = 0; i < nf * N; i++)
         pix[i] = rnd ? 8'($urandom_range(1, 255)) : 8'(i % N + 1);
   endtask

   // One cycle: sample outputs at the falling edge and set inputs for the next rising edge.
   task automatic step(input bit wantPix, input bit wantRdy);
      @(negedge iClk);
      cyc++;
      if (oFrameDone) fdCount++;
      if (chkLat && cyc == acc6 + 1) chk("latNotYet", 80'(oWindowValid), 80'(0));
      if (chkLat && cyc == acc6 + 2) chk("latFirstWin", 80'(oWindowValid), 80'(1));
      iPixelValid = wantPix && (pi < totalPix);
      iv8Pixel    = iPixelValid ? pix[pi] : 8'd0;
      if (iPixelValid && oReady) begin
         pi++;
         if (pi == 6) acc6 = cyc;
      end
      iWindowReady = wantRdy;
      if (oWindowValid && wantRdy) begin
         if (wi >= totalPix) chk("extraWin", 80'(wi), 80'(totalPix - 1));
         else begin
            got[wi] = winOut;
            chk($sformatf("win%0d", wi), 80'(winOut), 80'(expWin(wi)));
         end
         wi++;
      end
   endtask

   task automatic run(input int pixPct, input int rdyPct, input int maxCyc);
      int n = 0;
      while (wi < totalPix && n < maxCyc) begin
         step($urandom_range(0, 99) < pixPct, $urandom_range(0, 99) < rdyPct);
         n++;
      end
      if (wi < totalPix) chk("timeoutWindows", 80'(wi), 80'(totalPix));
      for (int i = 0; i < 3; i++) step(0, 0);
   endtask

   task automatic doReset();
      @(negedge iClk);
      iRst = 1; iPixelValid = 0; iWindowReady = 0; iv8Pixel = 0;
      @(negedge iClk);
      chk("resetState", 80'({oReady, oWindowValid, oFrameDone, winOut}), 80'(0));
      iRst = 0;
      @(negedge iClk);
      chk("readyAfterRst", 80'(oReady), 80'(1));
   endtask

   initial begin
      logic [71:0] snap;
      bit stable, snapSet;
      int stableCnt, n;
      tbl[0] = '{0,  {8'd0,  8'd0,  8'd0, 8'd0,  8'd1,  8'd2,  8'd0, 8'd5,  8'd6}};
      tbl[1] = '{5,  {8'd1,  8'd2,  8'd3, 8'd5,  8'd6,  8'd7,  8'd9, 8'd10, 8'd11}};
      tbl[2] = '{15, {8'd11, 8'd12, 8'd0, 8'd15, 8'd16, 8'd0,  8'd0, 8'd0,  8'd0}};
      tbl[3] = '{3,  {8'd0,  8'd0,  8'd0, 8'd3,  8'd4,  8'd0,  8'd7, 8'd8,  8'd0}};
      tbl[4] = '{12, {8'd0,  8'd9,  8'd10, 8'd0, 8'd13, 8'd14, 8'd0, 8'd0,  8'd0}};
      iRst = 1; iPixelValid = 0; iWindowReady = 0; iv8Pixel = 0;

      // Full-rate frame: latency, spot windows, single done pulse.
      doReset();
      newFrames(1, 0);
      chkLat = 1;
      run(100, 100, 200);
      chkLat = 0;
      foreach (tbl[t])
         chk($sformatf("spot%0d", tbl[t].idx), 80'(got[tbl[t].idx]), 80'(tbl[t].exp));
      chk("frameDone1", 80'(fdCount), 80'(1));

      // Backpressure: input stalls after W+3 accepts, window 0 held stable.
      doReset();
      newFrames(1, 0);
      stable = 1; snapSet = 0; stableCnt = 0; snap = '0;
      for (int i = 0; i < 32; i++) begin
         step(1, 0);
         if (oWindowValid) begin
            if (!snapSet) begin snap = winOut; snapSet = 1; end
            else begin
               if (winOut !== snap) stable = 0;
               stableCnt++;
            end
         end
      end
      chk("acceptsUnderBP", 80'(pi), 80'(7));
      chk("readyLowBP", 80'(oReady), 80'(0));
      chk("bpSnap", 80'(snap), 80'(expWin(0)));
      chk("bpStable", 80'({stable, stableCnt >= 20}), 80'(2'b11));
      run(100, 100, 200);
      chk("bpCount", 80'(wi), 80'(N));
      chk("bpFrameDone", 80'(fdCount), 80'(1));

      // Random gaps over three back-to-back frames.
      doReset();
      newFrames(3, 1);
      run(60, 55, 3000);
      chk("frameDone3", 80'(fdCount), 80'(3));

      // Mid-frame reset after the 9th accept.
      doReset();
      newFrames(1, 0);
      n = 0;
      while (pi < 9 && n < 100) begin step(1, 1); n++; end
      chk("reach9", 80'(pi), 80'(9));
      @(negedge iClk);
      iRst = 1; iPixelValid = 0; iWindowReady = 0;
      @(negedge iClk);
      chk("midRstZero", 80'({oReady, oWindowValid, oFrameDone, winOut}), 80'(0));
      iRst = 0;
      newFrames(1, 0);
      run(100, 100, 200);
      chk("fijAfterRst", 80'(got[0][39:32]), 80'(1));
      for (int i = 0; i < 5; i++) step(0, 1);
      chk("winCountAfterRst", 80'(wi), 80'(N));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
